// File: rtl/voice_phase_accumulator.sv
// Time-multiplexed polyphonic phase accumulator feeding the quarter-wave sine stage.
// One voice is serviced per clock after each sample tick; the top 16 phase bits
// leave with their voice index and gate so later stages can realign them.
module voice_phase_accumulator #(
    parameter int unsigned VOICES  = 8,
    parameter int unsigned VOICE_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_sample_tick,
    input  logic               i_wr_en,
    input  logic [VOICE_W-1:0] i_wr_voice,
    input  logic [31:0]        i_wr_tuning,
    input  logic               i_wr_gate,
    output logic [15:0]        o_phase,
    output logic [VOICE_W-1:0] o_voice,
    output logic               o_gate,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned PHASE_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [VOICE_W-1:0] cnt_q;
    logic [VOICE_W-1:0] cnt_d;

    logic svc_c;
    logic last_c;
    logic overrun_set_c;

    logic [ACC_W-1:0]  acc_q    [VOICES];
    logic [ACC_W-1:0]  tuning_q [VOICES];
    logic [VOICES-1:0] gate_q;

    logic             svc_gate_c;
    logic [ACC_W-1:0] svc_acc_c;
    logic             note_on_c;

    // Last voice of the round is being serviced.
    assign last_c = (cnt_q == VOICE_W'(VOICES - 1));

    // Service datapath: reads the registers before any same-cycle write lands.
    assign svc_gate_c = gate_q[cnt_q];
    assign svc_acc_c  = svc_gate_c ? (acc_q[cnt_q] + tuning_q[cnt_q]) : '0;

    // A write that raises a closed gate restarts that voice from phase zero.
    assign note_on_c = i_wr_en && i_wr_gate && !gate_q[i_wr_voice];

    // FSM state and voice counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one voice per RUN cycle, ticks during RUN are flagged, not obeyed.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        svc_c         = 1'b0;
        overrun_set_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_sample_tick) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                svc_c = 1'b1;
                cnt_d = cnt_q + VOICE_W'(1);
                if (i_sample_tick) begin
                    overrun_set_c = 1'b1;
                end
                if (last_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-voice control registers, writable in any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                tuning_q[i] <= '0;
            end
            gate_q <= '0;
        end else if (i_wr_en) begin
            tuning_q[i_wr_voice] <= i_wr_tuning;
            gate_q[i_wr_voice]   <= i_wr_gate;
        end
    end

    // Accumulators: advance on service, cleared on note-on (which wins if both hit one voice).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (svc_c) begin
                acc_q[cnt_q] <= svc_acc_c;
            end
            if (note_on_c) begin
                acc_q[i_wr_voice] <= '0;
            end
        end
    end

    // Registered output stage, one cycle behind the service.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_phase <= '0;
            o_voice <= '0;
            o_gate  <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_valid <= svc_c;
            o_busy  <= (state_d == RUN);
            if (svc_c) begin
                o_phase <= svc_acc_c[ACC_W-1 -: PHASE_W];
                o_voice <= cnt_q;
                o_gate  <= svc_gate_c;
            end
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_overrun <= 1'b0;
        end else if (overrun_set_c) begin
            o_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/voice_phase_accumulator.md
Name: voice_phase_accumulator

Overview:
- Time-multiplexed, polyphonic phase accumulator (NCO front end) that sits directly upstream of the quarter-wave sine stage.
- Holds one 32-bit phase accumulator and tuning word per voice.
- On each sample tick it services every voice in turn, one per clock, and emits the top 16 phase bits as the sine stage's 16-bit phase input.
- Voice index and gate travel alongside each phase, so downstream stages can realign them after the sine pipeline.

Parameters:
VOICES, 8, number of voices serviced per sample round (power of two, 2..64)
VOICE_W, 3, voice index width, equal to log2(VOICES)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_sample_tick  in  1  single-cycle pulse that starts one service round
i_wr_en  in  1  write strobe for the voice control registers
i_wr_voice  in  VOICE_W  voice addressed by the write
i_wr_tuning  in  32  tuning word (phase increment per sample)
i_wr_gate  in  1  gate value written with the tuning word (1 = voice sounding)
o_phase  out  16  accumulator bits [31:16] of the serviced voice
o_voice  out  VOICE_W  index of the voice presented on o_phase
o_gate  out  1  gate of the voice presented
o_valid  out  1  o_phase/o_voice/o_gate are valid this cycle
o_busy  out  1  a service round is in progress
o_overrun  out  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0.
  - All accumulators, tuning words and gates cleared to 0.
  - FSM enters IDLE.
- FSM states and transitions:
  - IDLE: wait for i_sample_tick; on tick, go to RUN with voice counter = 0.
  - RUN: service the voice selected by the counter this cycle and increment the counter.
  - After servicing voice VOICES-1, return to IDLE.
- Per-voice service, voice v in cycle t:
  - gate=1: acc[v] <= acc[v] + tuning[v], modulo 2^32 (natural wrap, no saturation).
  - gate=0: acc[v] <= 0.
- Registered outputs, presented in cycle t+1:
  - o_phase = new acc[v][31:16] (0 when gate=0).
  - o_voice = v, o_gate = gate[v], o_valid = 1.
- Timing:
  - Tick in cycle T gives o_valid high for exactly VOICES consecutive cycles, T+2 .. T+VOICES+1, with voices in ascending order 0..VOICES-1.
  - o_valid is 0 at all other times.
  - o_busy is high from T+1 through T+VOICES, i.e. while in RUN.
- Note-on: a write that raises gate from 0 starts the voice from accumulator 0. Its first emitted phase is tuning[31:16].
- Note-off: a write that clears gate zeroes the accumulator at that voice's next service.
- Control writes:
  - Accepted in any state; tuning and gate registers update at the clock edge.
  - A write to the voice being serviced in the same cycle is read-before-write: that service uses the old values and the new values apply from the next round.
  - A write to a voice not yet serviced in the current round takes effect in this round.
- Tick while busy, including a tick in the cycle a round ends:
  - The tick is ignored and the round continues unchanged.
  - o_overrun is set and stays 1 until reset.
- Reset asserted mid-round: the round aborts immediately, all state is cleared, and no further o_valid is produced.
- Phase output is unsigned 16-bit; the downstream sine stage interprets bit 15 as the half-cycle sign and bit 14 as the quadrant mirror.

Test Plan:
- Reset, gate voice 0 with tuning 0x00010000, issue 3 ticks -> voice 0 o_phase = 0x0001, 0x0002, 0x0003; voices 1..7 o_phase = 0, o_gate = 0.
- Voice 2 with tuning 0x80000000 over 4 ticks -> o_phase = 0x8000, 0x0000, 0x8000, 0x0000 (wrap-around).
- Single tick at cycle T -> o_valid high for cycles T+2..T+9 exactly, o_voice = 0..7 in order, o_busy high for T+1..T+8.
- Second tick 3 cycles after the first -> the round completes normally with 8 valids and no restart; o_overrun = 1 and stays 1 across later rounds.
- Write tuning 0x00020000 to voice 4 in the cycle voice 4 is serviced (old tuning 0x00010000) -> that round's increment is 0x0001, the next round's is 0x0002. Repeat the same write while voice 1 is being serviced -> voice 4 uses 0x0002 in the same round.
- Assert reset_n low during voice 5 service -> all outputs 0 asynchronously. After release and a new tick, gated voices restart from 0 with no residual valid.
